// File: rtl/vector_mem_xfer.sv
// Vector load/store engine: moves NUM_ELEM words between a packed vector and a
// single-word memory port, one element per accepted request.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   start, is_store      request a transfer (sampled only in idle); 1 = store, 0 = load
//   base_addr            word address of element 0, sampled with start
//   vec_in               vector to store, sampled with start (element i at [16i+15:16i])
//   vec_out              last fully loaded vector, updated atomically
//   busy, done           not-idle flag; one-cycle completion pulse
//   mem_addr, mem_wdata  current request address / store data
//   mem_we, mem_re       write / read request strobes
//   mem_rdata, mem_ready read data; request accepted at this edge
module vector_mem_xfer #(
    parameter int unsigned NUM_ELEM = 16,
    parameter int unsigned ELEM_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       is_store,
    input  logic [15:0]                base_addr,
    input  logic [NUM_ELEM*ELEM_W-1:0] vec_in,
    output logic [NUM_ELEM*ELEM_W-1:0] vec_out,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                mem_addr,
    output logic [ELEM_W-1:0]          mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    input  logic [ELEM_W-1:0]          mem_rdata,
    input  logic                       mem_ready
);

    localparam int unsigned IdxW = $clog2(NUM_ELEM);
    // One extra bit so the counter can hold NUM_ELEM after the final accept.
    localparam int unsigned CntW = IdxW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

    state_e                               state_q, state_d;
    logic [CntW-1:0]                      count_q, count_d;
    logic [15:0]                          base_q, base_d;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]      store_q, store_d;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]      shadow_q, shadow_d;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]      vec_out_q, vec_out_d;

    logic [IdxW-1:0] idx;
    logic [15:0]     cur_addr;
    logic            last_elem;

    assign idx       = count_q[IdxW-1:0];
    assign cur_addr  = base_q + {{(16-CntW){1'b0}}, count_q};
    assign last_elem = (count_q == CntW'(NUM_ELEM - 1));
    assign vec_out   = vec_out_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        base_d    = base_q;
        store_d   = store_q;
        shadow_d  = shadow_q;
        vec_out_d = vec_out_q;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    store_d = vec_in;
                    count_d = '0;
                    state_d = is_store ? StStore : StLoad;
                end
            end
            StLoad: begin
                mem_re   = 1'b1;
                mem_addr = cur_addr;
                if (mem_ready) begin
                    shadow_d[idx] = mem_rdata;
                    count_d       = count_q + 1'b1;
                    if (last_elem) begin
                        // Publish including the element landing this edge.
                        vec_out_d = shadow_d;
                        state_d   = StDone;
                    end
                end
            end
            StStore: begin
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = store_q[idx];
                if (mem_ready) begin
                    count_d = count_q + 1'b1;
                    if (last_elem) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            base_q    <= '0;
            store_q   <= '0;
            shadow_q  <= '0;
            vec_out_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            base_q    <= base_d;
            store_q   <= store_d;
            shadow_q  <= shadow_d;
            vec_out_q <= vec_out_d;
        end
    end

endmodule

// File: tb/tb_vector_mem_xfer.sv
// Directed bench for vector_mem_xfer. The memory model returns
// rdata_base + mem_addr when mem_ready is high, and 0xDEAD otherwise.
module tb_vector_mem_xfer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_store;
    logic [15:0]  base_addr;
    logic [255:0] vec_in;
    logic [255:0] vec_out;
    logic         busy;
    logic         done;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_we;
    logic         mem_re;
    logic [15:0]  mem_rdata;
    logic         mem_ready;
    logic [15:0]  rdata_base;

    int vectors     = 0;
    int miscompares = 0;

    logic [255:0] exp_ld1;
    logic [255:0] exp_st;

    vector_mem_xfer #(.NUM_ELEM(16), .ELEM_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .vec_in    (vec_in),
        .vec_out   (vec_out),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_ready ? (rdata_base + mem_addr) : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Element i = b + s*i (16-bit wrap).
    function automatic logic [255:0] ramp(input logic [15:0] b, input logic [15:0] s);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = b + s * 16'(i);
        return v;
    endfunction

    initial begin
        // Reset, with start and mem_ready asserted to show reset wins.
        rst_n = 1'b0; start = 1'b1; is_store = 1'b0; base_addr = 16'h1234;
        vec_in = '1; mem_ready = 1'b1; rdata_base = '0;
        tick(); tick();
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_we", mem_we, 1'b0);
        chk_b("rst_re", mem_re, 1'b0);
        chk_w("rst_addr", mem_addr, 16'h0000);
        chk_w("rst_wdata", mem_wdata, 16'h0000);
        chk_v("rst_vec_out", vec_out, '0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        chk_b("idle_busy", busy, 1'b0);

        // Load, mem_ready tied high, base 0x0010.
        exp_ld1 = ramp(16'h3C00, 16'h0001);
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0010; rdata_base = 16'h3BF0;
        tick();
        start = 1'b0; base_addr = 16'hBEEF; is_store = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_b("ld1_re", mem_re, 1'b1);
            chk_b("ld1_we", mem_we, 1'b0);
            chk_w("ld1_addr", mem_addr, 16'h0010 + 16'(i));
            chk_v("ld1_vec_hold", vec_out, '0);
            tick();
        end
        chk_b("ld1_done", done, 1'b1);
        chk_b("ld1_done_busy", busy, 1'b1);
        chk_b("ld1_done_re", mem_re, 1'b0);
        chk_v("ld1_vec_out", vec_out, exp_ld1);
        tick();
        chk_b("ld1_end_done", done, 1'b0);
        chk_b("ld1_end_busy", busy, 1'b0);

        // Store across the address wrap; vec_in disturbed after capture.
        exp_st = ramp(16'h0000, 16'h1000);
        start = 1'b1; is_store = 1'b1; base_addr = 16'hFFF8; vec_in = exp_st;
        tick();
        start = 1'b0; is_store = 1'b0; vec_in = ~exp_st; base_addr = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            chk_b("st_we", mem_we, 1'b1);
            chk_b("st_re", mem_re, 1'b0);
            chk_w("st_addr", mem_addr, 16'hFFF8 + 16'(i));
            chk_w("st_wdata", mem_wdata, 16'(i * 4096));
            tick();
        end
        chk_b("st_done", done, 1'b1);
        chk_b("st_done_we", mem_we, 1'b0);
        chk_v("st_vec_out", vec_out, exp_ld1);
        tick();
        chk_b("st_end_busy", busy, 1'b0);

        // Load with mem_ready low on odd cycles.
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0100; rdata_base = 16'h5000;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            mem_ready = (c % 2 == 0);
            chk_b("stall_re", mem_re, 1'b1);
            chk_w("stall_addr", mem_addr, 16'h0100 + 16'((c - 1) / 2));
            chk_v("stall_vec_hold", vec_out, exp_ld1);
            tick();
        end
        mem_ready = 1'b1;
        chk_b("stall_done", done, 1'b1);
        chk_v("stall_vec_out", vec_out, ramp(16'h5100, 16'h0001));
        tick();
        chk_b("stall_end_busy", busy, 1'b0);

        // start pulsed mid-transfer and during done: both ignored.
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0200; rdata_base = 16'h0000;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk_b("ign_re", mem_re, 1'b1);
            chk_w("ign_addr", mem_addr, 16'h0200 + 16'(c - 1));
            if (c == 5) begin
                start = 1'b1; is_store = 1'b1; base_addr = 16'h9999;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk_b("ign_done", done, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0; is_store = 1'b0;
        chk_b("ign_idle_busy", busy, 1'b0);
        chk_b("ign_idle_done", done, 1'b0);
        tick();
        chk_b("ign_no_new_busy", busy, 1'b0);
        chk_b("ign_no_new_we", mem_we, 1'b0);
        chk_v("ign_vec_out", vec_out, ramp(16'h0200, 16'h0001));

        // Reset during cycle 8 of a load, then a store right after.
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0300;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        chk_w("abort_addr_c8", mem_addr, 16'h0307);
        rst_n = 1'b0;
        tick();
        chk_b("abort_re", mem_re, 1'b0);
        chk_b("abort_we", mem_we, 1'b0);
        chk_b("abort_busy", busy, 1'b0);
        chk_b("abort_done", done, 1'b0);
        chk_w("abort_addr", mem_addr, 16'h0000);
        chk_v("abort_vec_out", vec_out, '0);
        rst_n = 1'b1; start = 1'b1; is_store = 1'b1; base_addr = 16'h0400;
        vec_in = ramp(16'hA000, 16'h0011);
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_b("post_we", mem_we, 1'b1);
            chk_w("post_addr", mem_addr, 16'h0400 + 16'(i));
            chk_w("post_wdata", mem_wdata, 16'hA000 + 16'(i * 17));
            tick();
        end
        chk_b("post_done", done, 1'b1);
        chk_v("post_vec_out", vec_out, '0);
        tick();

        // Back-to-back loads with start held high: 18 cycles each.
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0500; rdata_base = 16'h1000;
        tick();
        for (int c = 1; c <= 36; c++) begin
            chk_b("b2b_done", done, (c == 17 || c == 35));
            chk_b("b2b_busy", busy, !(c == 18 || c == 36));
            chk_b("b2b_re", mem_re, !(c == 17 || c == 18 || c == 35 || c == 36));
            if (c == 19) chk_w("b2b_addr_restart", mem_addr, 16'h0500);
            if (c == 35) start = 1'b0;
            tick();
        end
        chk_b("b2b_final_busy", busy, 1'b0);
        chk_v("b2b_vec_out", vec_out, ramp(16'h1500, 16'h0001));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vector_mem_xfer.md
VECTOR_MEM_XFER -- requirements
Module: vector_mem_xfer

Interface
REQ-001 Parameter: NUM_ELEM, 16, number of vector elements per transfer.
REQ-002 Parameter: ELEM_W, 16, element width in bits (one memory word).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 Port: start  input  1  request a transfer; sampled only in IDLE.
REQ-006 Port: is_store  input  1  transfer type, sampled with start: 1 = VST (vector to memory), 0 = VLD (memory to vector).
REQ-007 Port: base_addr  input  16  word address of element 0, sampled with start.
REQ-008 Port: vec_in  input  256  vector to store, sampled with start; element i = bits [16i+15:16i].
REQ-009 Port: vec_out  output  256  last fully loaded vector; same element packing as vec_in.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: mem_addr  output  16  word address of the current request.
REQ-013 Port: mem_wdata  output  16  store data of the current request.
REQ-014 Port: mem_we  output  1  write request strobe.
REQ-015 Port: mem_re  output  1  read request strobe.
REQ-016 Port: mem_rdata  input  16  read data; valid only in a cycle where mem_ready=1 and mem_re=1.
REQ-017 Port: mem_ready  input  1  memory accepts the current request at this rising edge.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, STORE, DONE; encoding free.
REQ-019 IDLE: start=1 SHALL capture is_store, base_addr, vec_in, clear element counter to 0, go to STORE if is_store else LOAD.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 LOAD/STORE: exactly one of mem_re/mem_we SHALL be 1; mem_addr = (base_addr + count) mod 2^16; mem_wdata = captured element[count] in STORE, 0 otherwise.
REQ-022 Request (addr, wdata, strobe) SHALL be held stable until an edge with mem_ready=1; mem_ready in IDLE/DONE SHALL be ignored.
REQ-023 On accepted request, counter SHALL increment; in LOAD, mem_rdata SHALL be written into shadow element[count].
REQ-024 After element NUM_ELEM-1 is accepted, FSM SHALL enter DONE; LOAD SHALL copy the full shadow to vec_out on that same edge (vec_out changes atomically, never partially).
REQ-025 DONE SHALL last exactly one cycle with done=1, busy=1, no memory strobe, then return to IDLE.
REQ-026 STORE SHALL NOT modify vec_out.
REQ-027 Latency with mem_ready tied 1: start at edge 0, requests in cycles 1..16, done=1 in cycle 17, start accepted again in cycle 18; each low mem_ready cycle adds one cycle.
REQ-028 Address wrap: base_addr+count SHALL wrap modulo 2^16 with no flag.
REQ-029 Counter SHALL be 5 bits wide; no path SHALL issue a 17th request.
REQ-030 Changes to vec_in/base_addr/is_store after capture SHALL not affect the transfer in progress.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, counter 0, busy=0, done=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, vec_out=0, shadow=0.
REQ-032 Reset mid-transfer SHALL abort immediately; vec_out SHALL read 0, no done pulse, start accepted on first edge after rst_n=1.
REQ-033 Reset has priority over start and mem_ready in the same cycle.

Verification
REQ-034 VLD, mem_ready=1, base=0x0010, memory[0x10+i]=0x3C00+i -> addresses 0x0010..0x001F in cycles 1..16, done in cycle 17, vec_out element i = 0x3C00+i.
REQ-035 VST, base=0xFFF8, vec_in element i = 0x1000*i -> writes to 0xFFF8..0xFFFF then 0x0000..0x0007 with matching data, vec_out unchanged.
REQ-036 VLD with mem_ready low on every other cycle -> request held stable while low, 16 reads total, done in cycle 33, vec_out unchanged until that edge.
REQ-037 start pulsed in cycles 5 and 17 of an active transfer -> ignored, single done pulse, no new transfer.
REQ-038 rst_n=0 during cycle 8 of a VLD -> strobes 0 next edge, vec_out=0, no done; new VST started after reset completes normally.
REQ-039 Back-to-back: start held high continuously -> new transfer captured in IDLE cycle after each done, exactly 18 cycles per transfer with mem_ready=1.
